alu_exec: RTL and testbench

Multi-cycle 16-bit execute unit that consumes the 4-bit ALU operation code and `invB` qualifier produced by the ALU control decoder. It sits in the EX stage and uses a valid/ready handshake toward decode and writeback. Add, sub, logic and compare ops complete in one cycle. Shifts and rotates iterate one bit position per cycle so the datapath needs no barrel shifter. It returns the result and condition flags that the set/branch logic consumes.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_exec_if.sv | 32 +++
 rtl/alu_shift_step.sv | 22 ++
 rtl/alu_exec.sv | 137 +++++++++++++
 tb/tb_alu_exec.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM encoding and datapath width for the execute unit
package alu_pkg;

    localparam int WIDTH = 16;

    localparam logic [3:0] OP_ROL = 4'b0000;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_ROR = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_CMP = 4'b0111;
    localparam logic [3:0] OP_SUB = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - operation/result handshake bundle between decode, execute and writeback
// master drives in_valid/op/invB/A/B/out_ready; slave (the execute unit) drives
// in_ready/out_valid/result/zero/neg/ofl/cout/err.
interface alu_exec_if;
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic             invB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             ofl;
    logic             cout;
    logic             err;

    modport master (
        output in_valid, op, invB, A, B, out_ready,
        input  in_ready, out_valid, result, zero, neg, ofl, cout, err
    );

    modport slave (
        input  in_valid, op, invB, A, B, out_ready,
        output in_ready, out_valid, result, zero, neg, ofl, cout, err
    );

endinterface

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - one-position shift/rotate of r selected by kind
// r: value in; kind: 0 rol, 1 sll, 2 ror, 3 srl; y: r moved by one bit.
module alu_shift_step
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] r,
    input  logic [1:0]       kind,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = r;
        case (kind)
            2'd0: y = {r[WIDTH-2:0], r[WIDTH-1]};
            2'd1: y = {r[WIDTH-2:0], 1'b0};
            2'd2: y = {r[0], r[WIDTH-1:1]};
            2'd3: y = {1'b0, r[WIDTH-1:1]};
            default: y = r;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - multi-cycle 16-bit execute unit, single-cycle arithmetic/logic, bit-serial shifts
// clk, rst (sync, active high); bus: slave side of alu_exec_if carrying the
// operation handshake in and the result/flags handshake out.
module alu_exec
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu_exec_if.slave   bus
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] r;
    logic [3:0]       cnt;
    logic [1:0]       kind;
    logic             zero_q, neg_q, ofl_q, cout_q, err_q;

    logic             in_ready_c, out_valid_c;
    logic             accept, shift_go;
    logic [WIDTH-1:0] bp, step_r, calc_res;
    logic [WIDTH:0]   sum;
    logic             calc_ofl, calc_cout, calc_err;

    // The output register doubles as the shift accumulator.
    alu_shift_step u_step (
        .r    (r),
        .kind (kind),
        .y    (step_r)
    );

    assign accept   = bus.in_valid && (state == IDLE);
    // A zero-distance shift takes the one-cycle path with result = A.
    assign shift_go = (bus.op[3:2] == 2'b00) && (bus.B[3:0] != 4'd0);

    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (accept) state_nx = shift_go ? SHIFT : DONE;
            end
            SHIFT: begin
                if (cnt == 4'd1) state_nx = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle result path; subtraction is x + ~y + 1 so cout means "no borrow".
    always_comb begin
        bp        = bus.invB ? ~bus.B : bus.B;
        sum       = '0;
        calc_res  = '0;
        calc_ofl  = 1'b0;
        calc_cout = 1'b0;
        calc_err  = 1'b0;
        case (bus.op)
            OP_ROL, OP_SLL, OP_ROR, OP_SRL: calc_res = bus.A;
            OP_ADD: begin
                sum       = {1'b0, bus.A} + {1'b0, bp};
                calc_res  = sum[WIDTH-1:0];
                calc_cout = sum[WIDTH];
                calc_ofl  = (bus.A[WIDTH-1] == bp[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_XOR: calc_res = bus.A ^ bp;
            OP_AND: calc_res = bus.A & bp;
            OP_CMP: begin
                sum       = {1'b0, bus.A} + {1'b0, ~bp} + {{WIDTH{1'b0}}, 1'b1};
                calc_res  = sum[WIDTH-1:0];
                calc_cout = sum[WIDTH];
                calc_ofl  = (bus.A[WIDTH-1] != bp[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                sum       = {1'b0, bus.B} + {1'b0, ~bus.A} + {{WIDTH{1'b0}}, 1'b1};
                calc_res  = sum[WIDTH-1:0];
                calc_cout = sum[WIDTH];
                calc_ofl  = (bus.B[WIDTH-1] != bus.A[WIDTH-1]) && (sum[WIDTH-1] != bus.B[WIDTH-1]);
            end
            default: calc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            r      <= '0;
            cnt    <= 4'd0;
            kind   <= 2'd0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ofl_q  <= 1'b0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                kind   <= bus.op[1:0];
                cnt    <= bus.B[3:0];
                ofl_q  <= shift_go ? 1'b0 : calc_ofl;
                cout_q <= shift_go ? 1'b0 : calc_cout;
                err_q  <= shift_go ? 1'b0 : calc_err;
                if (shift_go) begin
                    r      <= bus.A;
                    zero_q <= 1'b0;
                    neg_q  <= 1'b0;
                end else begin
                    r      <= calc_res;
                    zero_q <= (calc_res == '0);
                    neg_q  <= calc_res[WIDTH-1];
                end
            end else if (state == SHIFT) begin
                r   <= step_r;
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    zero_q <= (step_r == '0);
                    neg_q  <= step_r[WIDTH-1];
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = r;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ofl       = ofl_q;
    assign bus.cout      = cout_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - self-checking bench for alu_exec against an arithmetic reference model
module tb_alu_exec;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_exec_if bus ();

    alu_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    task automatic model(input logic [3:0] op, input logic inv, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] res,
                         output logic [4:0] flags, output int lat);
        int ua, ub, ubp, sa, sbp, sb, t, n;
        logic [15:0] bpv;
        logic o, c, e;
        bpv = inv ? ~b : b;
        ua = int'(a);
        ub = int'(b);
        ubp = int'(bpv);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sbp = int'($signed(bpv));
        n = int'(b[3:0]);
        o = 1'b0; c = 1'b0; e = 1'b0; lat = 1; t = 0;
        case (op)
            4'd0: begin t = (ua << n) | (ua >> (16 - n)); lat = 1 + n; end
            4'd1: begin t = ua << n; lat = 1 + n; end
            4'd2: begin t = (ua >> n) | (ua << (16 - n)); lat = 1 + n; end
            4'd3: begin t = ua >> n; lat = 1 + n; end
            4'd4: begin
                t = ua + ubp;
                c = (t > 32'hFFFF);
                o = ((sa + sbp) > 32767) || ((sa + sbp) < -32768);
            end
            4'd5: t = ua ^ ubp;
            4'd6: t = ua & ubp;
            4'd7: begin
                t = ua - ubp;
                c = (ua >= ubp);
                o = ((sa - sbp) > 32767) || ((sa - sbp) < -32768);
            end
            4'd8: begin
                t = ub - ua;
                c = (ub >= ua);
                o = ((sb - sa) > 32767) || ((sb - sa) < -32768);
            end
            default: begin t = 0; e = 1'b1; end
        endcase
        res = t[15:0];
        flags = {(res == 16'h0), res[15], o, c, e};
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic inv,
                         input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] eres;
        logic [4:0]  eflags;
        int          elat, lat, w;
        logic        busy_ok;
        model(op, inv, a, b, eres, eflags, elat);
        w = 0;
        while (!bus.in_ready && w < 50) begin tick(); w++; end
        check({tag, ".ready_wait"}, 32'(bus.in_ready), 32'd1);
        bus.op = op; bus.invB = inv; bus.A = a; bus.B = b; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom); bus.invB = 1'($urandom);
        bus.A = 16'($urandom); bus.B = 16'($urandom);
        lat = 1; busy_ok = 1'b1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (bus.in_ready) busy_ok = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".in_ready_low"}, 32'(busy_ok), 32'd1);
        check({tag, ".result"}, 32'(bus.result), 32'(eres));
        check({tag, ".flags_znocE"}, 32'({bus.zero, bus.neg, bus.ofl, bus.cout, bus.err}), 32'(eflags));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.op = 4'd4; bus.A = 16'h1234; bus.B = 16'h1111;
            tick();
            check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".hold_result"}, 32'(bus.result), 32'(eres));
            check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ".drain_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".drain_ready"}, 32'(bus.in_ready), 32'd1);
        if (hold > 0) begin
            tick();
            check({tag, ".no_capture"}, 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [3:0] rop;
        int         seen;
        bus.in_valid = 1'b0; bus.op = 4'd0; bus.invB = 1'b0;
        bus.A = 16'h0; bus.B = 16'h0; bus.out_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.result", 32'(bus.result), 32'd0);
        check("reset.flags", 32'({bus.zero, bus.neg, bus.ofl, bus.cout, bus.err}), 32'd0);

        do_op("add_ofl", 4'd4, 1'b0, 16'h7FFF, 16'h0001, 0);
        check("add_ofl.result_const", 32'(bus.result), 32'h8000);
        do_op("cmp_eq", 4'd7, 1'b0, 16'h0005, 16'h0005, 0);
        do_op("cmp_lt", 4'd7, 1'b0, 16'h0003, 16'h0005, 0);
        do_op("ror4", 4'd2, 1'b0, 16'h0001, 16'h0004, 0);
        check("ror4.result_const", 32'(bus.result), 32'h1000);
        do_op("sll0", 4'd1, 1'b0, 16'h8001, 16'h0000, 0);
        do_op("and_inv_hold", 4'd6, 1'b1, 16'hF0F0, 16'hFF00, 10);
        do_op("sub", 4'd8, 1'b0, 16'h0001, 16'h8000, 0);
        do_op("reserved", 4'd11, 1'b0, 16'hABCD, 16'h1234, 0);
        do_op("add_after_err", 4'd4, 1'b0, 16'h0001, 16'h0001, 0);

        // Reset in the middle of a 15-step srl: nothing may come out afterwards.
        bus.op = 4'd3; bus.invB = 1'b0; bus.A = 16'hFFFF; bus.B = 16'h000F; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid.in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mid.result", 32'(bus.result), 32'd0);
        check("rst_mid.flags", 32'({bus.zero, bus.neg, bus.ofl, bus.cout, bus.err}), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        check("rst_mid.no_out_valid", 32'(seen), 32'd0);

        for (int k = 0; k < 60; k++) begin
            rop = 4'($urandom_range(0, 9));
            if (rop == 4'd9) rop = 4'($urandom_range(9, 15));
            do_op($sformatf("rand%0d", k), rop, 1'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
